// File: rtl/rv32_pkg.sv
// Shared RV32 core definitions: opcodes, M-extension funct3 encodings
// and multiply/divide constants.
package rv32_pkg;

  typedef enum logic [6:0] {
    LUI            = 7'b0110111,
    AUIPC          = 7'b0010111,
    JAL            = 7'b1101111,
    JALR           = 7'b1100111,
    BRANCH         = 7'b1100011,
    LOAD           = 7'b0000011,
    STORE          = 7'b0100011,
    ARITHMETIC_IMM = 7'b0010011,
    ARITHMETIC_REG = 7'b0110011,
    SYSTEM         = 7'b1110011
  } instr_t;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_t;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam int         MULDIV_STEPS  = 32;

endpackage

// File: rtl/muldiv_datapath.sv
// Operand magnitude capture, shift-add / restoring-divide iteration,
// sign fix-up and the registered result word.
module muldiv_datapath
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            finalize,
  input  logic            is_div,
  input  muldiv_op_t      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            special,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  logic [2*XLEN-1:0] prod, prod_n, prod_fix;
  logic [XLEN-1:0]   mcand, dvsr, quo, quo_n, quo_fix;
  logic [XLEN-1:0]   rem, rem_n, rem_fix, abs_a, abs_b, res_n;
  logic [XLEN:0]     psum, shifted, trial;
  logic              neg_p, neg_q, neg_r;
  logic              sgn_a, sgn_b, sa, sb, ovf, dz;

  always_comb begin
    sgn_a = (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    sgn_b = (op == MULH) || (op == DIV) || (op == REM);
    sa    = sgn_a & a[XLEN-1];
    sb    = sgn_b & b[XLEN-1];
    abs_a = sa ? -a : a;
    abs_b = sb ? -b : b;
    dz    = is_div & (b == '0);
    ovf   = ((op == DIV) || (op == REM)) & (a == MIN_INT) & (b == '1);
    special = dz | ovf;

    psum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_n = {psum, prod[XLEN-1:1]};

    // 33-bit trial keeps the borrow of the restoring step
    shifted = {rem, quo[XLEN-1]};
    trial   = shifted - {1'b0, dvsr};
    rem_n   = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    quo_n   = {quo[XLEN-2:0], ~trial[XLEN]};

    prod_fix = neg_p ? -prod_n : prod_n;
    quo_fix  = neg_q ? -quo_n : quo_n;
    rem_fix  = neg_r ? -rem_n : rem_n;

    res_n = result;
    if (load) begin
      if (op[1]) res_n = ovf ? '0 : a;
      else       res_n = ovf ? MIN_INT : '1;
    end else if (is_div) begin
      res_n = op[1] ? rem_fix : quo_fix;
    end else begin
      res_n = (op == MUL) ? prod_fix[XLEN-1:0]
                          : prod_fix[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod   <= '0;
      mcand  <= '0;
      dvsr   <= '0;
      rem    <= '0;
      quo    <= '0;
      neg_p  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else begin
      if (load) begin
        mcand <= abs_a;
        dvsr  <= abs_b;
        prod  <= {{XLEN{1'b0}}, abs_b};
        rem   <= '0;
        quo   <= abs_a;
        neg_p <= sa ^ sb;
        neg_q <= sa ^ sb;
        neg_r <= sa;
      end else if (step) begin
        if (is_div) begin
          rem <= rem_n;
          quo <= quo_n;
        end else begin
          prod <= prod_n;
        end
      end
      if (finalize) result <= res_n;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle multiply/divide sequencer: IDLE/RUN/DONE control,
// iteration counter and core stall generation.
module muldiv_sequencer
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            stall_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [4:0] cnt, cnt_n;
  muldiv_op_t op_q, op_sel;
  logic       load, step, finalize, is_div, special;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= MUL;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (load) op_q <= op_sel;
    end
  end

  always_comb begin
    op_sel   = (state == IDLE) ? muldiv_op_t'(op_i) : op_q;
    is_div   = op_sel[2];
    state_n  = state;
    cnt_n    = cnt;
    load     = 1'b0;
    step     = 1'b0;
    finalize = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i && !flush_i) begin
          load  = 1'b1;
          cnt_n = 5'(MULDIV_STEPS - 1);
          // special results are known at accept, so skip RUN
          if (special) begin
            finalize = 1'b1;
            state_n  = DONE;
          end else begin
            state_n = RUN;
          end
        end
      end
      RUN: begin
        if (flush_i) begin
          state_n = IDLE;
        end else begin
          step  = 1'b1;
          cnt_n = cnt - 5'd1;
          if (cnt == 5'd0) begin
            finalize = 1'b1;
            state_n  = DONE;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy_o  = (state == RUN);
  assign done_o  = (state == DONE);
  assign stall_o = start_i & ~done_o;

  muldiv_datapath #(.XLEN(XLEN)) u_dp (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (load),
    .step     (step),
    .finalize (finalize),
    .is_div   (is_div),
    .op       (op_sel),
    .a        (rs1_i),
    .b        (rs2_i),
    .special  (special),
    .result   (result_o)
  );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic results, latency,
// stall window, special cases, flush, reset and back-to-back issue.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        flush = 1'b0;
  logic        busy, done, stall;
  logic [31:0] result;

  int total = 0;
  int bad = 0;

  muldiv_sequencer dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .op_i     (op),
    .rs1_i    (rs1),
    .rs2_i    (rs2),
    .flush_i  (flush),
    .busy_o   (busy),
    .done_o   (done),
    .stall_o  (stall),
    .result_o (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          cyc;
  } vec_t;

  // Issue one op at the next falling edge and wait for done_o.
  // Cycle 0 is the accept cycle; cyc = -1 on timeout.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit drop,
                        output int cyc, output logic [31:0] res,
                        output bit stall_ok);
    bit got;
    got = 0;
    cyc = -1;
    res = 'x;
    stall_ok = 1;
    @(negedge clk);
    start = 1'b1;
    op = o;
    rs1 = a;
    rs2 = b;
    #1;
    for (int i = 0; i < 100 && !got; i++) begin
      if (done) begin
        got = 1;
        cyc = i;
        res = result;
        if (stall) stall_ok = 0;
      end else begin
        if (!stall) stall_ok = 0;
        @(negedge clk);
        #1;
      end
    end
    if (drop) start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    total++;
    if ({busy, done, stall} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000", {busy, done, stall});
    end
    total++;
    if (result !== 32'h0) begin
      bad++;
      $display("FAIL reset_result got=%h want=00000000", result);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_arith;
    vec_t v[10];
    int c;
    logic [31:0] r;
    bit s;
    v[0] = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    v[1] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33};
    v[2] = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    v[3] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    v[4] = '{3'd0, 32'd3,        32'd5,        32'd15,       33};
    v[5] = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 33};
    v[6] = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    v[7] = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    v[8] = '{3'd5, 32'd100,      32'd7,        32'd14,       33};
    v[9] = '{3'd7, 32'd100,      32'd7,        32'd2,        33};
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, 1, c, r, s);
      total++;
      if (r !== v[i].exp || c != v[i].cyc || !s) begin
        bad++;
        $display("FAIL arith[%0d] op=%0d got res=%h cyc=%0d stall=%0b want res=%h cyc=%0d stall=1",
                 i, v[i].op, r, c, s, v[i].exp, v[i].cyc);
      end
    end
    @(negedge clk);
    #1;
    total++;
    if (result !== 32'd2 || done !== 1'b0) begin
      bad++;
      $display("FAIL result_hold got res=%h done=%b want res=00000002 done=0",
               result, done);
    end
  endtask

  task automatic test_flush;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    op = 3'd0;
    rs1 = 32'd3;
    rs2 = 32'd5;
    repeat (10) @(negedge clk);
    #1;
    total++;
    if (busy !== 1'b1 || stall !== 1'b1) begin
      bad++;
      $display("FAIL flush_pre got busy=%b stall=%b want 1 1", busy, stall);
    end
    flush = 1'b1;
    start = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd2) begin
      bad++;
      $display("FAIL flush_post got busy=%b done=%b res=%h want 0 0 00000002",
               busy, done, result);
    end
    flush = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    total++;
    if (seen || result !== 32'd2) begin
      bad++;
      $display("FAIL flush_quiet got activity=%0b res=%h want 0 00000002",
               seen, result);
    end
  endtask

  task automatic test_special;
    vec_t v[4];
    int c;
    logic [31:0] r;
    bit s;
    v[0] = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    v[1] = '{3'd6, 32'd5,        32'd0,        32'd5,        1};
    v[2] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    v[3] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, 1, c, r, s);
      total++;
      if (r !== v[i].exp || c != v[i].cyc || !s) begin
        bad++;
        $display("FAIL special[%0d] op=%0d got res=%h cyc=%0d stall=%0b want res=%h cyc=%0d stall=1",
                 i, v[i].op, r, c, s, v[i].exp, v[i].cyc);
      end
    end
  endtask

  task automatic test_back_to_back;
    int c1, c2;
    logic [31:0] r1, r2;
    bit s1, s2;
    run_op(3'd0, 32'd3, 32'd5, 0, c1, r1, s1);
    total++;
    if (r1 !== 32'd15 || c1 != 33) begin
      bad++;
      $display("FAIL b2b_first got res=%h cyc=%0d want 0000000f 33", r1, c1);
    end
    run_op(3'd5, 32'd15, 32'd4, 1, c2, r2, s2);
    total++;
    if (r2 !== 32'd3 || c1 + 1 + c2 != 67 || !s2) begin
      bad++;
      $display("FAIL b2b_second got res=%h cyc=%0d stall=%0b want 00000003 67 1",
               r2, c1 + 1 + c2, s2);
    end
  endtask

  task automatic test_async_reset;
    int c;
    logic [31:0] r;
    bit s;
    @(negedge clk);
    start = 1'b1;
    op = 3'd5;
    rs1 = 32'd100;
    rs2 = 32'd7;
    repeat (20) @(negedge clk);
    #1;
    total++;
    if (busy !== 1'b1 || result !== 32'd3) begin
      bad++;
      $display("FAIL rst_pre got busy=%b res=%h want 1 00000003", busy, result);
    end
    rst = 1'b1;
    start = 1'b0;
    #1;
    total++;
    if ({busy, done, stall} !== 3'b000 || result !== 32'h0) begin
      bad++;
      $display("FAIL rst_mid got flags=%b res=%h want 000 00000000",
               {busy, done, stall}, result);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(3'd5, 32'd100, 32'd7, 1, c, r, s);
    total++;
    if (r !== 32'd14 || c != 33) begin
      bad++;
      $display("FAIL rst_recover got res=%h cyc=%0d want 0000000e 33", r, c);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_flush();
    test_special();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
